mcast_fork: RTL and testbench
=============================

Name: mcast_fork

Overview:
- Per-input-port flit dispatcher that sits directly downstream of the route decoder and input VC FIFO.
- On a head flit it latches the decoder results (output port, multicast mode, pruned multicast address) for the whole packet.
- Every flit then goes to the forward branch (switch request), the local eject branch, or both.
- Multicast-absorb packets are duplicated flit-by-flit; the forwarded head carries the pruned multicast address.

Parameters:
- FLIT_W, 35, flit width; bits [FLIT_W-1:FLIT_W-2] are the flit type.
- MADDR_W, 20, multicast one-hot address width (5x4 mesh).
- MADDR_LSB, 0, LSB position of the multicast address field inside a head flit.
- PORT_W, 5, width of the decoder port code; passed through unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  FIFO head flit valid
- in_flit  in  FLIT_W  FIFO head flit
- in_ready  out  1  pop strobe to FIFO; combinational
- rt_port  in  PORT_W  decoder port for the current head flit
- rt_multab  in  2  decoder mode: `UNICAST / `MULTFWD / `MULTABS
- rt_addr1_rm  in  MADDR_W  decoder pruned multicast address
- fwd_valid  out  1  forward-branch flit valid
- fwd_flit  out  FLIT_W  forward-branch flit
- fwd_port  out  PORT_W  latched output port for the packet
- fwd_ready  in  1  switch accepts forward flit
- ej_valid  out  1  eject-branch flit valid
- ej_flit  out  FLIT_W  eject-branch flit (unmodified)
- ej_ready  in  1  local PE accepts eject flit
- busy  out  1  packet in progress (state XFER)
- err  out  1  one-cycle pulse: non-head flit received in IDLE

Behaviour:
- Flit type codes: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 head+tail (single-flit packet).
- State machine has two states, IDLE and XFER. Reset is async and forces IDLE with all latched registers cleared.
- Reset values: fwd_valid=0, ej_valid=0, in_ready=0, busy=0, err=0, fwd_port=0.
- IDLE, in_valid with a head or head+tail flit:
  - Register rt_port into fwd_port, and rt_addr1_rm.
  - need_f = (mode != `MULTABS) | (rt_addr1_rm != 0).
  - need_e = (mode == `MULTABS).
  - Go to XFER next cycle. No pop in this cycle. Route-latch latency is 1 cycle.
- IDLE, in_valid with a body or tail flit: in_ready=1 (discard), err=1 for that cycle, stay IDLE.
- `UNICAST and `MULTFWD packets use the forward branch only.
- `MULTABS with nonzero addr1_rm uses both branches. `MULTABS with zero addr1_rm uses eject only.
- Reserved mode 2'b11 is treated as `UNICAST.
- XFER branch outputs:
  - fwd_valid = in_valid & need_f & ~f_done.
  - ej_valid = in_valid & need_e & ~e_done.
  - ej_flit = in_flit.
  - fwd_flit = in_flit, except that on a head or head+tail flit the field [MADDR_LSB+MADDR_W-1:MADDR_LSB] is replaced by the latched addr1_rm.
- Per-flit sent bits f_done and e_done:
  - Set on a branch accept (valid & ready) when the flit is not popped that cycle.
  - Cleared on pop.
  - This lets the two branches accept in different cycles without duplicating a copy.
- Pop: in_ready = XFER & in_valid & (~need_f | f_done | fwd_ready) & (~need_e | e_done | ej_ready).
- Pop of a tail or head+tail flit returns the block to IDLE. The next head can be latched in the cycle after the tail pop.
- Packet throughput is one flit per cycle when all required readies are high.
- in_valid low in XFER stalls the block: outputs are invalid and done bits are held.
- fwd_port and the latched mode stay stable for the whole packet, even if rt_* inputs change.
- Reset mid-packet: immediately return to IDLE and clear the done bits. The rest of the packet arriving afterwards is discarded with err pulses.

Test Plan:
- Unicast, 4-flit packet, rt_port=5'b00100, fwd_ready=1 throughout -> fwd_valid on cycles 2..5, fwd_port=5'b00100, 4 pops, ej_valid never asserted, busy falls after the tail pop.
- `MULTABS, rt_addr1_rm=20'h00100, 3 flits, fwd_ready and ej_ready both high -> both branches see each flit in the same cycle; forwarded head addr field=20'h00100; ejected head field unchanged.
- `MULTABS, ej_ready low for 3 cycles while fwd_ready=1 -> forward copy sent once (f_done set), no duplicate; pop happens in the cycle ej_ready rises.
- `MULTABS, rt_addr1_rm=0, single head+tail flit -> eject only, fwd_valid stays 0, back to IDLE after 1 pop.
- Body flit with in_valid in IDLE -> in_ready=1 and err=1 for one cycle, state stays IDLE.
- Assert rst in the middle of a 4-flit packet after 2 flits -> outputs go to 0 asynchronously; the remaining 2 flits are discarded, each with an err pulse.

Source files
------------

// File: rtl/mcast_fork.sv
// Purpose: per-input-port flit dispatcher; steers each flit of a packet to the forward branch, the local eject branch, or both.
// Latency: 1 cycle to latch the route on a head flit, then 1 flit/cycle; flit outputs are combinational from the FIFO head.
// Backpressure: a flit is popped only once every branch it needs has accepted it; per-branch done bits prevent duplicate copies.
//
// Ports:
//   clk, rst                              clock, asynchronous active-high reset
//   in_valid/in_flit/in_ready             FIFO head flit and combinational pop strobe
//   rt_port/rt_multab/rt_addr1_rm         route decoder results for the current head flit
//   fwd_valid/fwd_flit/fwd_port/fwd_ready forward (switch request) branch
//   ej_valid/ej_flit/ej_ready             local eject branch
//   busy                                  packet in progress
//   err                                   one-cycle pulse when a non-head flit arrives while idle
module mcast_fork #(
  parameter int FLIT_W    = 35,
  parameter int MADDR_W   = 20,
  parameter int MADDR_LSB = 0,
  parameter int PORT_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              in_ready,
  input  logic [PORT_W-1:0] rt_port,
  input  logic [1:0]        rt_multab,
  input  logic [MADDR_W-1:0] rt_addr1_rm,
  output logic              fwd_valid,
  output logic [FLIT_W-1:0] fwd_flit,
  output logic [PORT_W-1:0] fwd_port,
  input  logic              fwd_ready,
  output logic              ej_valid,
  output logic [FLIT_W-1:0] ej_flit,
  input  logic              ej_ready,
  output logic              busy,
  output logic              err
);

  // Decoder modes: 2'b00 unicast, 2'b01 multicast-forward, 2'b10 multicast-absorb.
  // The reserved code 2'b11 falls through to forward-only like unicast.
  localparam logic [1:0] MODE_MULTABS = 2'b10;

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state_q, state_d;
  logic [PORT_W-1:0]  port_q, port_d;
  logic [MADDR_W-1:0] addr_q, addr_d;
  logic               need_f_q, need_f_d;
  logic               need_e_q, need_e_d;
  logic               f_done_q, f_done_d;
  logic               e_done_q, e_done_d;

  logic [1:0] in_type;
  logic       is_head;
  logic       is_tail;

  // Type codes: 01 head, 00 body, 10 tail, 11 head+tail.
  // Bit 0 marks a head, bit 1 marks the end of the packet.
  assign in_type = in_flit[FLIT_W-1 -: 2];
  assign is_head = in_type[0];
  assign is_tail = in_type[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      port_q   <= '0;
      addr_q   <= '0;
      need_f_q <= 1'b0;
      need_e_q <= 1'b0;
      f_done_q <= 1'b0;
      e_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      addr_q   <= addr_d;
      need_f_q <= need_f_d;
      need_e_q <= need_e_d;
      f_done_q <= f_done_d;
      e_done_q <= e_done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    addr_d   = addr_q;
    need_f_d = need_f_q;
    need_e_d = need_e_q;
    f_done_d = f_done_q;
    e_done_d = e_done_q;

    fwd_valid = 1'b0;
    ej_valid  = 1'b0;
    in_ready  = 1'b0;
    err       = 1'b0;

    // Only the forwarded head carries the pruned address; the eject copy is untouched.
    fwd_flit = in_flit;
    if (is_head) begin
      fwd_flit[MADDR_LSB +: MADDR_W] = addr_q;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_head) begin
            // Latch the route; the head stays in the FIFO and is sent next cycle.
            port_d   = rt_port;
            addr_d   = rt_addr1_rm;
            need_f_d = (rt_multab != MODE_MULTABS) || (rt_addr1_rm != '0);
            need_e_d = (rt_multab == MODE_MULTABS);
            f_done_d = 1'b0;
            e_done_d = 1'b0;
            state_d  = XFER;
          end else begin
            // Orphan body/tail: drop it and flag it.
            in_ready = 1'b1;
            err      = 1'b1;
          end
        end
      end
      XFER: begin
        fwd_valid = in_valid && need_f_q && !f_done_q;
        ej_valid  = in_valid && need_e_q && !e_done_q;
        in_ready  = in_valid
                    && (!need_f_q || f_done_q || fwd_ready)
                    && (!need_e_q || e_done_q || ej_ready);
        if (in_ready) begin
          f_done_d = 1'b0;
          e_done_d = 1'b0;
          if (is_tail) begin
            state_d = IDLE;
          end
        end else begin
          // Remember which branch already took this flit so it is not sent twice.
          if (fwd_valid && fwd_ready) begin
            f_done_d = 1'b1;
          end
          if (ej_valid && ej_ready) begin
            e_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pop and error strobes are quiet while reset is held, even with a flit waiting.
    if (rst) begin
      in_ready = 1'b0;
      err      = 1'b0;
    end
  end

  assign ej_flit  = in_flit;
  assign fwd_port = port_q;
  assign busy     = (state_q == XFER);

endmodule

// File: tb/tb_mcast_fork.sv
module tb_mcast_fork;

  localparam int FW = 35;
  localparam int AW = 20;
  localparam int PW = 5;
  localparam logic [1:0] UNI  = 2'b00;
  localparam logic [1:0] MABS = 2'b10;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [FW-1:0] in_flit;
  logic          in_ready;
  logic [PW-1:0] rt_port;
  logic [1:0]    rt_multab;
  logic [AW-1:0] rt_addr1_rm;
  logic          fwd_valid;
  logic [FW-1:0] fwd_flit;
  logic [PW-1:0] fwd_port;
  logic          fwd_ready;
  logic          ej_valid;
  logic [FW-1:0] ej_flit;
  logic          ej_ready;
  logic          busy;
  logic          err;

  mcast_fork #(.FLIT_W(FW), .MADDR_W(AW), .MADDR_LSB(0), .PORT_W(PW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
    .rt_port(rt_port), .rt_multab(rt_multab), .rt_addr1_rm(rt_addr1_rm),
    .fwd_valid(fwd_valid), .fwd_flit(fwd_flit), .fwd_port(fwd_port), .fwd_ready(fwd_ready),
    .ej_valid(ej_valid), .ej_flit(ej_flit), .ej_ready(ej_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] flit;
    logic [PW-1:0] port;
    logic [1:0]    mode;
    logic [AW-1:0] addr;
  } src_t;

  src_t          src_q[$];
  logic [FW-1:0] fwd_q[$];
  logic [PW-1:0] port_q[$];
  logic [FW-1:0] ej_q[$];
  logic [FW-1:0] disc_q[$];

  int checks   = 0;
  int errors   = 0;
  int err_exp  = 0;
  int err_seen = 0;
  bit f_rand = 1'b0, e_rand = 1'b0, gap_en = 1'b0;
  logic f_force = 1'b1, e_force = 1'b1;

  function automatic logic [FW-1:0] mk_flit(input logic [1:0] t);
    logic [FW-1:0] f;
    f = '0;
    f[31:0] = $urandom;
    f[32] = 1'($urandom);
    f[FW-1:FW-2] = t;
    return f;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: forward copies exist unless absorbing with an empty pruned set;
  // eject copies exist only when absorbing. Forwarded head gets the pruned address.
  task automatic add_pkt(input logic [1:0] mode, input logic [AW-1:0] addr,
                         input logic [PW-1:0] port, input int len);
    src_t e;
    logic [1:0] t;
    logic [FW-1:0] ff;
    bit nf, ne;
    nf = (mode != MABS) || (addr != 0);
    ne = (mode == MABS);
    for (int i = 0; i < len; i++) begin
      t = (len == 1) ? 2'b11 : (i == 0) ? 2'b01 : (i == len - 1) ? 2'b10 : 2'b00;
      e.flit = mk_flit(t);
      e.port = port;
      e.mode = mode;
      e.addr = addr;
      src_q.push_back(e);
      ff = e.flit;
      if (i == 0) ff[AW-1:0] = addr;
      if (nf) begin
        fwd_q.push_back(ff);
        port_q.push_back(port);
      end
      if (ne) ej_q.push_back(e.flit);
    end
  endtask

  task automatic add_stray(input logic [1:0] t);
    src_t e;
    e.flit = mk_flit(t);
    e.port = 5'($urandom);
    e.mode = 2'($urandom);
    e.addr = 20'($urandom);
    src_q.push_back(e);
    disc_q.push_back(e.flit);
    err_exp++;
  endtask

  task automatic drive_rand_rt();
    rt_port     = 5'($urandom);
    rt_multab   = 2'($urandom);
    rt_addr1_rm = 20'($urandom);
  endtask

  task automatic run_cycle();
    @(posedge clk);
    #1;
    if (src_q.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
      in_valid = 1'b1;
      in_flit  = src_q[0].flit;
      if (src_q[0].flit[FW-2]) begin
        rt_port     = src_q[0].port;
        rt_multab   = src_q[0].mode;
        rt_addr1_rm = src_q[0].addr;
      end else begin
        drive_rand_rt();
      end
    end else begin
      in_valid = 1'b0;
      in_flit  = mk_flit(2'($urandom));
      drive_rand_rt();
    end
    fwd_ready = f_rand ? 1'($urandom) : f_force;
    ej_ready  = e_rand ? 1'($urandom) : e_force;
    @(negedge clk);
    if (in_ready) begin
      checks++;
      if (!in_valid || src_q.size() == 0) begin
        errors++;
        $display("FAIL pop_without_valid: in_ready=1 in_valid=%0b", in_valid);
      end else begin
        void'(src_q.pop_front());
      end
    end
  endtask

  task automatic drain(input int maxc, output int used);
    used = 0;
    while (src_q.size() > 0 && used < maxc) begin
      run_cycle();
      used++;
    end
    if (src_q.size() > 0) begin
      chk("drain_timeout", 64'(src_q.size()), 64'd0);
      src_q.delete();
    end
  endtask

  // Monitor: every accepted branch flit and every error pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (fwd_valid && fwd_ready) begin
        checks++;
        if (fwd_q.size() == 0) begin
          errors++;
          $display("FAIL fwd_unexpected: got flit %h, none expected", fwd_flit);
        end else begin
          logic [FW-1:0] ef;
          logic [PW-1:0] ep;
          ef = fwd_q.pop_front();
          ep = port_q.pop_front();
          if (fwd_flit !== ef || fwd_port !== ep) begin
            errors++;
            $display("FAIL fwd_flit: got %h port %h expected %h port %h", fwd_flit, fwd_port, ef, ep);
          end
        end
      end
      if (ej_valid && ej_ready) begin
        checks++;
        if (ej_q.size() == 0) begin
          errors++;
          $display("FAIL ej_unexpected: got flit %h, none expected", ej_flit);
        end else begin
          logic [FW-1:0] ee;
          ee = ej_q.pop_front();
          if (ej_flit !== ee) begin
            errors++;
            $display("FAIL ej_flit: got %h expected %h", ej_flit, ee);
          end
        end
      end
      if (err) begin
        checks++;
        err_seen++;
        if (disc_q.size() == 0 || !in_ready) begin
          errors++;
          $display("FAIL err_pulse: unexpected err (in_ready=%0b pending=%0d)", in_ready, disc_q.size());
        end else begin
          logic [FW-1:0] ed;
          ed = disc_q.pop_front();
          if (in_flit !== ed) begin
            errors++;
            $display("FAIL err_flit: got %h expected %h", in_flit, ed);
          end
        end
      end
    end
  end

  initial begin
    int n;
    logic [1:0] md;
    logic [AW-1:0] ad;

    // Reset with an orphan body flit waiting: everything must stay quiet.
    rst = 1'b1;
    in_valid = 1'b1;
    in_flit = mk_flit(2'b00);
    fwd_ready = 1'b1;
    ej_ready = 1'b1;
    drive_rand_rt();
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst_ej_valid", 64'(ej_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fwd_port", 64'(fwd_port), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst = 1'b0;

    // Unicast 4 flits, all ready: 1 latch cycle + 4 pops.
    add_pkt(UNI, 20'($urandom), 5'b00100, 4);
    drain(20, n);
    chk("uni_cycles", 64'(n), 64'd5);
    run_cycle();
    chk("uni_busy_after", 64'(busy), 64'd0);

    // Absorb with both branches: one pop per cycle, both copies together.
    add_pkt(MABS, 20'h00100, 5'($urandom), 3);
    drain(20, n);
    chk("mabs_cycles", 64'(n), 64'd4);
    run_cycle();

    // Eject stalled 3 cycles: forward copy sent once, pop when eject ready returns.
    add_pkt(MABS, 20'h00abc, 5'($urandom), 3);
    run_cycle();
    e_force = 1'b0;
    repeat (3) run_cycle();
    chk("stall_no_pop", 64'(src_q.size()), 64'd3);
    e_force = 1'b1;
    drain(20, n);
    chk("stall_rest_cycles", 64'(n), 64'd3);
    run_cycle();

    // Absorb with empty pruned set, single flit: eject only.
    add_pkt(MABS, 20'h0, 5'($urandom), 1);
    drain(20, n);
    chk("mabs0_cycles", 64'(n), 64'd2);
    run_cycle();
    chk("mabs0_busy_after", 64'(busy), 64'd0);

    // Orphan body while idle: discarded with an error pulse, no state change.
    add_stray(2'b00);
    drain(20, n);
    chk("stray_cycles", 64'(n), 64'd1);
    chk("stray_busy", 64'(busy), 64'd0);

    // Reset after two flits of a 4-flit packet; the remainder becomes orphans.
    add_pkt(UNI, 20'($urandom), 5'($urandom), 4);
    repeat (3) run_cycle();
    chk("midrst_pops", 64'(src_q.size()), 64'd2);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_flit = src_q[0].flit;
    drive_rand_rt();
    fwd_ready = 1'b1;
    ej_ready = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    fwd_q.delete();
    port_q.delete();
    foreach (src_q[i]) begin
      disc_q.push_back(src_q[i].flit);
      err_exp++;
    end
    #1;
    rst = 1'b0;
    @(negedge clk);
    if (in_ready) void'(src_q.pop_front());
    chk("midrst_discard1", 64'(src_q.size()), 64'd1);
    drain(10, n);
    chk("midrst_discard2_cycles", 64'(n), 64'd1);
    run_cycle();

    // Randomized traffic with random readies, input gaps and stray flits.
    f_rand = 1'b1;
    e_rand = 1'b1;
    gap_en = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0) add_stray($urandom_range(0, 1) == 0 ? 2'b00 : 2'b10);
      md = 2'($urandom);
      if (k % 4 == 0) md = MABS;
      ad = ($urandom_range(0, 2) == 0) ? 20'h0 : 20'($urandom);
      add_pkt(md, ad, 5'($urandom), $urandom_range(1, 5));
    end
    drain(20000, n);
    f_rand = 1'b0;
    e_rand = 1'b0;
    gap_en = 1'b0;
    repeat (3) run_cycle();

    chk("end_fwd_pending", 64'(fwd_q.size()), 64'd0);
    chk("end_ej_pending", 64'(ej_q.size()), 64'd0);
    chk("end_disc_pending", 64'(disc_q.size()), 64'd0);
    chk("end_err_count", 64'(err_seen), 64'(err_exp));
    chk("end_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
